stopwatch_timer: RTL and testbench

- Parametrised successor of the MM:SS stopwatch: BCD minutes/seconds counter driven by a cycle prescaler.
- Adds count-down timer mode with preset load and an expiry flag.
- Adds an up-count overflow pulse and a lap-capture FIFO with a pop handshake.
- Sits between the debounced button/control logic and the 7-segment display driver.

---
 rtl/stopwatch_pkg.sv | 89 ++++++++
 rtl/stopwatch_timer_lap_fifo.sv | 73 +++++++
 rtl/stopwatch_timer.sv | 143 ++++++++++++++
 tb/tb_stopwatch_timer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and BCD step helpers for the MM:SS stopwatch/timer.
package stopwatch_pkg;

  localparam int unsigned TIME_W  = 16;
  localparam int unsigned DIGIT_W = 4;

  localparam logic MODE_UP   = 1'b0;
  localparam logic MODE_DOWN = 1'b1;

  typedef struct packed {
    logic [DIGIT_W-1:0] min_tens;
    logic [DIGIT_W-1:0] min_ones;
    logic [DIGIT_W-1:0] sec_tens;
    logic [DIGIT_W-1:0] sec_ones;
  } bcd_time_t;

  // Time after one step plus the carry (up) or borrow (down) out of min_tens.
  typedef struct packed {
    bcd_time_t t;
    logic      c;
  } bcd_step_t;

  function automatic bcd_step_t bcd_inc(input bcd_time_t t);
    bcd_step_t r;
    r.t = t;
    r.c = 1'b0;
    if (t.sec_ones != 4'd9) begin
      r.t.sec_ones = t.sec_ones + 4'd1;
    end else begin
      r.t.sec_ones = 4'd0;
      if (t.sec_tens != 4'd5) begin
        r.t.sec_tens = t.sec_tens + 4'd1;
      end else begin
        r.t.sec_tens = 4'd0;
        if (t.min_ones != 4'd9) begin
          r.t.min_ones = t.min_ones + 4'd1;
        end else begin
          r.t.min_ones = 4'd0;
          if (t.min_tens != 4'd9) begin
            r.t.min_tens = t.min_tens + 4'd1;
          end else begin
            r.t.min_tens = 4'd0;
            r.c          = 1'b1;
          end
        end
      end
    end
    return r;
  endfunction

  function automatic bcd_step_t bcd_dec(input bcd_time_t t);
    bcd_step_t r;
    r.t = t;
    r.c = 1'b0;
    if (t.sec_ones != 4'd0) begin
      r.t.sec_ones = t.sec_ones - 4'd1;
    end else begin
      r.t.sec_ones = 4'd9;
      if (t.sec_tens != 4'd0) begin
        r.t.sec_tens = t.sec_tens - 4'd1;
      end else begin
        r.t.sec_tens = 4'd5;
        if (t.min_ones != 4'd0) begin
          r.t.min_ones = t.min_ones - 4'd1;
        end else begin
          r.t.min_ones = 4'd9;
          if (t.min_tens != 4'd0) begin
            r.t.min_tens = t.min_tens - 4'd1;
          end else begin
            r.t.min_tens = 4'd9;
            r.c          = 1'b1;
          end
        end
      end
    end
    return r;
  endfunction

  // Out-of-range digits saturate at the digit's maximum.
  function automatic bcd_time_t bcd_clamp(input bcd_time_t t);
    bcd_time_t r;
    r.min_tens = (t.min_tens > 4'd9) ? 4'd9 : t.min_tens;
    r.min_ones = (t.min_ones > 4'd9) ? 4'd9 : t.min_ones;
    r.sec_tens = (t.sec_tens > 4'd5) ? 4'd5 : t.sec_tens;
    r.sec_ones = (t.sec_ones > 4'd9) ? 4'd9 : t.sec_ones;
    return r;
  endfunction

endpackage

// File: rtl/stopwatch_timer_lap_fifo.sv
// Lap-capture FIFO: first-word fall-through head, flush, and a drop strobe
// for pushes that arrive while full without a same-cycle pop.
module lap_fifo
  import stopwatch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = TIME_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             empty,
  output logic             full,
  output logic             drop
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_wr;
  logic             do_rd;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_rd    = pop && !empty;
  // A pop frees the head slot this edge, so a push while full still lands.
  assign do_wr    = push && (!full || pop);
  assign drop     = push && full && !pop;
  assign data_out = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_wr) begin
        mem_d[wr_ptr_q[AW-1:0]] = data_in;
        wr_ptr_d                = wr_ptr_q + PTR_ONE;
      end
      if (do_rd) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: the head is masked to zero while empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/stopwatch_timer.sv
// BCD MM:SS stopwatch with count-down timer mode, overflow pulse and lap FIFO.
module stopwatch_timer
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICK_COUNT = 10,
  parameter int unsigned LAP_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_stop,
  input  logic              clr,
  input  logic              mode,
  input  logic              load,
  input  logic [TIME_W-1:0] preset,
  input  logic              lap,
  input  logic              lap_rd,
  output logic [3:0]        sec_ones,
  output logic [3:0]        sec_tens,
  output logic [3:0]        min_ones,
  output logic [3:0]        min_tens,
  output logic              running,
  output logic              expired,
  output logic              overflow,
  output logic [TIME_W-1:0] lap_data,
  output logic              lap_valid,
  output logic              lap_full,
  output logic              lap_ovf
);

  localparam int unsigned PRESC_W = $clog2(TICK_COUNT);
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_COUNT - 1);
  localparam logic [PRESC_W-1:0] PRESC_ONE  = PRESC_W'(1);

  bcd_time_t          time_q, time_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               running_q, running_d;
  logic               mode_q, mode_d;
  logic               expired_q, expired_d;
  logic               overflow_q, overflow_d;
  logic               lap_ovf_q, lap_ovf_d;

  bcd_step_t          inc_r;
  bcd_step_t          dec_r;
  logic               fifo_empty;
  logic               fifo_drop;

  assign inc_r = bcd_inc(time_q);
  assign dec_r = bcd_dec(time_q);

  // Events are mutually exclusive in priority order: clr, load, start_stop, tick.
  always_comb begin
    time_d     = time_q;
    presc_d    = presc_q;
    running_d  = running_q;
    mode_d     = mode_q;
    expired_d  = expired_q;
    overflow_d = 1'b0;
    lap_ovf_d  = lap_ovf_q | fifo_drop;

    if (clr) begin
      time_d    = '0;
      presc_d   = '0;
      expired_d = 1'b0;
      lap_ovf_d = 1'b0;
    end else if (load && !running_q) begin
      time_d    = bcd_clamp(bcd_time_t'(preset));
      presc_d   = '0;
      expired_d = 1'b0;
    end else if (start_stop) begin
      if (running_q) begin
        running_d = 1'b0;
      end else if (!(mode == MODE_DOWN && time_q == '0)) begin
        running_d = 1'b1;
        mode_d    = mode;
      end
    end else if (running_q) begin
      if (presc_q != PRESC_LAST) begin
        presc_d = presc_q + PRESC_ONE;
      end else begin
        presc_d = '0;
        if (mode_q == MODE_UP) begin
          time_d     = inc_r.t;
          overflow_d = inc_r.c;
        end else if (dec_r.c || dec_r.t == '0) begin
          // Reaching (or already sitting at) zero ends the count-down.
          time_d    = '0;
          expired_d = 1'b1;
          running_d = 1'b0;
        end else begin
          time_d = dec_r.t;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      time_q     <= '0;
      presc_q    <= '0;
      running_q  <= 1'b0;
      mode_q     <= MODE_UP;
      expired_q  <= 1'b0;
      overflow_q <= 1'b0;
      lap_ovf_q  <= 1'b0;
    end else begin
      time_q     <= time_d;
      presc_q    <= presc_d;
      running_q  <= running_d;
      mode_q     <= mode_d;
      expired_q  <= expired_d;
      overflow_q <= overflow_d;
      lap_ovf_q  <= lap_ovf_d;
    end
  end

  // Laps capture the pre-edge time; clr flushes and wins over push/pop.
  lap_fifo #(
    .DEPTH(LAP_DEPTH),
    .WIDTH(TIME_W)
  ) u_lap_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (lap && !clr),
    .pop     (lap_rd && !clr),
    .flush   (clr),
    .data_in (TIME_W'(time_q)),
    .data_out(lap_data),
    .empty   (fifo_empty),
    .full    (lap_full),
    .drop    (fifo_drop)
  );

  assign sec_ones  = time_q.sec_ones;
  assign sec_tens  = time_q.sec_tens;
  assign min_ones  = time_q.min_ones;
  assign min_tens  = time_q.min_tens;
  assign running   = running_q;
  assign expired   = expired_q;
  assign overflow  = overflow_q;
  assign lap_ovf   = lap_ovf_q;
  assign lap_valid = !fifo_empty;

endmodule

// File: tb/tb_stopwatch_timer.sv
// Directed bench for stopwatch_timer with hand-computed expected values.
module tb_stopwatch_timer;

  localparam logic [4:0] P_SS   = 5'b10000;
  localparam logic [4:0] P_CLR  = 5'b01000;
  localparam logic [4:0] P_LOAD = 5'b00100;
  localparam logic [4:0] P_LAP  = 5'b00010;
  localparam logic [4:0] P_RD   = 5'b00001;

  logic        clk;
  logic        reset;
  logic        start_stop, clr, mode, load, lap, lap_rd;
  logic [15:0] preset;
  logic [3:0]  sec_ones, sec_tens, min_ones, min_tens;
  logic        running, expired, overflow, lap_valid, lap_full, lap_ovf;
  logic [15:0] lap_data;
  logic [15:0] disp;

  int n_checks;
  int n_errors;
  int ovf_cnt;

  stopwatch_timer #(
    .TICK_COUNT(10),
    .LAP_DEPTH (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start_stop(start_stop),
    .clr       (clr),
    .mode      (mode),
    .load      (load),
    .preset    (preset),
    .lap       (lap),
    .lap_rd    (lap_rd),
    .sec_ones  (sec_ones),
    .sec_tens  (sec_tens),
    .min_ones  (min_ones),
    .min_tens  (min_tens),
    .running   (running),
    .expired   (expired),
    .overflow  (overflow),
    .lap_data  (lap_data),
    .lap_valid (lap_valid),
    .lap_full  (lap_full),
    .lap_ovf   (lap_ovf)
  );

  assign disp = {min_tens, min_ones, sec_tens, sec_ones};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive a one-cycle pulse on {start_stop, clr, load, lap, lap_rd}.
  task automatic pulse(input logic [4:0] m);
    {start_stop, clr, load, lap, lap_rd} = m;
    @(negedge clk);
    {start_stop, clr, load, lap, lap_rd} = 5'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_time"},     disp,            16'h0000);
    check_eq({tag, "_running"},  16'(running),    16'h0);
    check_eq({tag, "_expired"},  16'(expired),    16'h0);
    check_eq({tag, "_overflow"}, 16'(overflow),   16'h0);
    check_eq({tag, "_lap_valid"},16'(lap_valid),  16'h0);
    check_eq({tag, "_lap_full"}, 16'(lap_full),   16'h0);
    check_eq({tag, "_lap_ovf"},  16'(lap_ovf),    16'h0);
    check_eq({tag, "_lap_data"}, lap_data,        16'h0000);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b0;
    {start_stop, clr, load, lap, lap_rd} = 5'b0;
    mode   = 1'b0;
    preset = 16'h0000;

    // Reset, then basic up count with pause/resume.
    cycles(2);
    reset = 1'b1;
    check_reset_state("rst");
    pulse(P_SS);
    cycles(70);
    check_eq("up_7s", disp, 16'h0007);
    check_eq("up_run", 16'(running), 16'h1);
    pulse(P_SS);
    cycles(10);
    check_eq("pause_hold", disp, 16'h0007);
    check_eq("pause_run", 16'(running), 16'h0);
    pulse(P_SS);
    cycles(1200);
    check_eq("up_2m07", disp, 16'h0207);

    // Preset clamp and 99:59 wrap.
    pulse(P_SS);
    preset = 16'hAF7C;
    pulse(P_LOAD);
    check_eq("load_clamp", disp, 16'h9959);
    preset = 16'h9958;
    pulse(P_LOAD);
    check_eq("load_9958", disp, 16'h9958);
    pulse(P_SS);
    ovf_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (overflow) ovf_cnt++;
    end
    check_eq("wrap_time", disp, 16'h0000);
    check_eq("wrap_ovf_now", 16'(overflow), 16'h1);
    cycles(1);
    check_eq("wrap_ovf_drop", 16'(overflow), 16'h0);
    check_eq("wrap_ovf_cnt", 16'(ovf_cnt), 16'h1);
    check_eq("wrap_run", 16'(running), 16'h1);

    // Count-down to expiry.
    pulse(P_SS);
    mode   = 1'b1;
    preset = 16'h0003;
    pulse(P_LOAD);
    check_eq("dn_load", disp, 16'h0003);
    pulse(P_SS);
    cycles(30);
    check_eq("dn_time", disp, 16'h0000);
    check_eq("dn_expired", 16'(expired), 16'h1);
    check_eq("dn_stopped", 16'(running), 16'h0);
    pulse(P_SS);
    check_eq("dn_restart_blk", 16'(running), 16'h0);
    pulse(P_CLR);
    check_eq("dn_clr_exp", 16'(expired), 16'h0);
    mode = 1'b0;

    // Lap FIFO: ordering, empty pop, full/drop, push+pop when full.
    pulse(P_SS);
    mode = 1'b1;
    cycles(20);
    check_eq("mode_ignored", disp, 16'h0002);
    pulse(P_LAP);
    cycles(29);
    check_eq("lap_t5", disp, 16'h0005);
    pulse(P_LAP);
    check_eq("lap_head0", lap_data, 16'h0002);
    check_eq("lap_valid1", 16'(lap_valid), 16'h1);
    check_eq("lap_notfull", 16'(lap_full), 16'h0);
    pulse(P_RD);
    check_eq("lap_head1", lap_data, 16'h0005);
    pulse(P_RD);
    check_eq("lap_empty", 16'(lap_valid), 16'h0);
    check_eq("lap_empty_data", lap_data, 16'h0000);
    pulse(P_RD);
    check_eq("lap_rd_empty", 16'(lap_valid), 16'h0);
    for (int k = 0; k < 5; k++) begin
      pulse(P_LAP);
      if (k < 4) cycles(9);
    end
    check_eq("fill_full", 16'(lap_full), 16'h1);
    check_eq("fill_ovf", 16'(lap_ovf), 16'h1);
    check_eq("fill_oldest", lap_data, 16'h0005);
    pulse(P_LAP | P_RD);
    check_eq("pp_full", 16'(lap_full), 16'h1);
    check_eq("pp_head", lap_data, 16'h0006);
    check_eq("pp_ovf_sticky", 16'(lap_ovf), 16'h1);
    mode = 1'b0;

    // clr while running with laps queued; load while running ignored.
    pulse(P_CLR);
    check_eq("clr_ovf", 16'(lap_ovf), 16'h0);
    pulse(P_LAP);
    pulse(P_LAP);
    cycles(118);
    check_eq("pre_clr_time", disp, 16'h0012);
    check_eq("pre_clr_valid", 16'(lap_valid), 16'h1);
    pulse(P_CLR);
    check_eq("clr_time", disp, 16'h0000);
    check_eq("clr_valid", 16'(lap_valid), 16'h0);
    check_eq("clr_run", 16'(running), 16'h1);
    cycles(20);
    check_eq("clr_count", disp, 16'h0002);
    preset = 16'h1234;
    pulse(P_LOAD);
    check_eq("load_running", disp, 16'h0002);
    check_eq("load_running_run", 16'(running), 16'h1);

    // Mid-run reset.
    cycles(879);
    check_eq("t_1m30", disp, 16'h0130);
    pulse(P_LAP);
    check_eq("lap_1m30", lap_data, 16'h0130);
    reset = 1'b0;
    cycles(1);
    reset = 1'b1;
    check_reset_state("mid_rst");
    pulse(P_SS);
    cycles(10);
    check_eq("post_rst_count", disp, 16'h0001);
    check_eq("post_rst_run", 16'(running), 16'h1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
